ct_merge_rr: RTL and testbench

Packet-aware N-input round-robin merge for the ct interconnect fabric. It is the parametrised successor to the fixed-priority merge node: arbitrary radix, fair round-robin arbitration, a grant that holds until end-of-packet, and an optional registered output stage. It sits wherever several transmit streams converge onto one link, typically ahead of a `ct_field_conv` or an endpoint input.

---
 rtl/ct_pkg.sv | 18 +
 rtl/ct_skid_buf.sv | 43 ++++
 rtl/ct_merge_rr.sv | 120 ++++++++++++
 tb/tb_ct_merge_rr.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ct_pkg.sv
// ct_pkg: shared types and helpers for the ct interconnect merge blocks.
package ct_pkg;

    localparam int EOP_NONE = -1;

    typedef enum logic {
        IDLE,
        HOLD
    } ct_state_e;

    function automatic int ct_clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/ct_skid_buf.sv
// ct_skid_buf: 2-entry output buffer whose upstream ready depends only on its own occupancy.
module ct_skid_buf
    import ct_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    logic [1:0]       r_cnt;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic             w_push;
    logic             w_pop;

    assign o_ready = (r_cnt != 2'd2);
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = o_valid ? r_head : '0;
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

    // r_head is always the oldest entry; r_tail only holds data while full
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt  <= 2'd0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
            if (w_pop) r_head <= (r_cnt == 2'd2) ? r_tail : i_data;
            else if (w_push && r_cnt == 2'd0) r_head <= i_data;
            if (w_push && !w_pop && r_cnt == 2'd1) r_tail <= i_data;
        end
    end

endmodule

// File: rtl/ct_merge_rr.sv
// ct_merge_rr: packet-aware N-input round-robin merge with optional registered output.
// The grant locks onto a lane from its first presented beat until that lane's eop beat transfers.
module ct_merge_rr
    import ct_pkg::*;
#(
    parameter  int RADIX   = 2,
    parameter  int WIDTH   = 19,
    parameter  int EOP_LOC = 0,
    parameter  int OUT_REG = 0,
    localparam int SW      = (ct_clog2(RADIX) > 1) ? ct_clog2(RADIX) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [RADIX*WIDTH-1:0] i_data,
    input  logic [RADIX-1:0]       i_valid,
    output logic [RADIX-1:0]       o_ready,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [SW-1:0]          o_sel
);

    ct_state_e        r_state;
    logic [SW-1:0]    r_grant;
    logic [SW-1:0]    r_ptr;
    logic [SW-1:0]    w_idx [RADIX];
    logic [RADIX-1:0] w_hit;
    logic [SW-1:0]    w_scan;
    logic             w_any;
    logic [SW-1:0]    w_grant;
    logic [SW-1:0]    w_ptr_nxt;
    logic [WIDTH-1:0] w_lane;
    logic             w_req;
    logic             w_eop;
    logic             w_core_ready;
    logic             w_xfer;

    // w_idx[j] is the lane visited j steps after ptr, wrapping modulo RADIX
    generate
        for (genvar j = 0; j < RADIX; j++) begin : g_scan
            assign w_idx[j] = (int'(r_ptr) + j >= RADIX) ? SW'(int'(r_ptr) + j - RADIX)
                                                         : SW'(int'(r_ptr) + j);
            assign w_hit[j] = i_valid[w_idx[j]];
        end
    endgenerate

    always_comb begin
        w_scan = '0;
        w_any  = 1'b0;
        for (int j = RADIX - 1; j >= 0; j--) begin
            if (w_hit[j]) begin
                w_scan = w_idx[j];
                w_any  = 1'b1;
            end
        end
    end

    assign w_grant   = (r_state == IDLE) ? w_scan : r_grant;
    assign w_ptr_nxt = (int'(w_grant) == RADIX - 1) ? '0 : w_grant + 1'b1;
    assign w_lane    = i_data[int'(w_grant)*WIDTH +: WIDTH];
    assign w_req     = (r_state == IDLE) ? w_any : i_valid[w_grant];
    assign w_xfer    = reset && w_req && w_core_ready;

    generate
        if (EOP_LOC == EOP_NONE) begin : g_no_eop
            assign w_eop = 1'b1;
        end else begin : g_eop
            assign w_eop = w_lane[EOP_LOC];
        end
    endgenerate

    always_comb begin
        o_ready          = '0;
        o_ready[w_grant] = reset && w_core_ready && (r_state == HOLD || w_any);
    end

    // A presented beat that does not finish its packet pins the grant until eop
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
        end else if (r_state == IDLE) begin
            if (w_xfer && w_eop) begin
                r_ptr <= w_ptr_nxt;
            end else if (w_any) begin
                r_state <= HOLD;
                r_grant <= w_scan;
            end
        end else if (w_xfer && w_eop) begin
            r_state <= IDLE;
            r_ptr   <= w_ptr_nxt;
        end
    end

    generate
        if (OUT_REG == 0) begin : g_comb
            assign w_core_ready = i_ready;
            assign o_valid      = reset && w_req;
            assign o_data       = o_valid ? w_lane : '0;
            assign o_sel        = o_valid ? w_grant : '0;
        end else begin : g_reg
            logic [SW+WIDTH-1:0] w_buf;
            ct_skid_buf #(
                .WIDTH(SW + WIDTH)
            ) u_skid (
                .clk    (clk),
                .reset  (reset),
                .i_data ({w_grant, w_lane}),
                .i_valid(w_req),
                .o_ready(w_core_ready),
                .o_data (w_buf),
                .o_valid(o_valid),
                .i_ready(i_ready)
            );
            assign {o_sel, o_data} = w_buf;
        end
    endgenerate

endmodule

// File: tb/tb_ct_merge_rr.sv
// tb_ct_merge_rr: randomized and directed checks of two ct_merge_rr configurations against a lane-level model.
module tb_ct_merge_rr;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] a_data;
    logic [3:0]  a_valid, a_ordy;
    logic [7:0]  a_odata;
    logic        a_ovalid, a_irdy;
    logic [1:0]  a_sel;

    logic [23:0] b_data;
    logic [2:0]  b_valid, b_ordy;
    logic [7:0]  b_odata;
    logic        b_ovalid, b_irdy;
    logic [1:0]  b_sel;

    ct_merge_rr #(.RADIX(4), .WIDTH(8), .EOP_LOC(0), .OUT_REG(0)) u_a (
        .clk(clk), .reset(rst), .i_data(a_data), .i_valid(a_valid), .o_ready(a_ordy),
        .o_data(a_odata), .o_valid(a_ovalid), .i_ready(a_irdy), .o_sel(a_sel)
    );

    ct_merge_rr #(.RADIX(3), .WIDTH(8), .EOP_LOC(-1), .OUT_REG(1)) u_b (
        .clk(clk), .reset(rst), .i_data(b_data), .i_valid(b_valid), .o_ready(b_ordy),
        .o_data(b_odata), .o_valid(b_ovalid), .i_ready(b_irdy), .o_sel(b_sel)
    );

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int rad[2] = '{4, 3};
    bit lv[2][4];
    logic [7:0] ld[2][4];
    int lock[2], ptr[2];
    logic [9:0] bq[$];
    int unsigned pv[2], pe, pr;
    logic [3:0] en[2];
    bit tog, want_rst;
    int cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: refresh upstream lanes, check outputs against the model, then advance the model.
    task automatic step(input int rr_exp);
        int g[2];
        bit any[2], hold[2], req[2], core[2], xfer[2], eop[2];
        logic [3:0] eo[2];
        @(negedge clk);
        cyc++;
        rst = !want_rst;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < rad[d]; k++)
                if (!lv[d][k] && en[d][k] && $urandom_range(99) < pv[d]) begin
                    lv[d][k] = 1'b1;
                    ld[d][k] = 8'($urandom);
                    if (d == 0) ld[d][k][0] = ($urandom_range(99) < pe);
                end
        a_irdy = ($urandom_range(99) < pr);
        b_irdy = tog ? cyc[0] : ($urandom_range(99) < pr);
        for (int k = 0; k < 4; k++) begin
            a_valid[k] = lv[0][k];
            a_data[k*8 +: 8] = ld[0][k];
        end
        for (int k = 0; k < 3; k++) begin
            b_valid[k] = lv[1][k];
            b_data[k*8 +: 8] = ld[1][k];
        end
        #2;
        for (int d = 0; d < 2; d++) begin
            hold[d] = (lock[d] >= 0);
            any[d] = 1'b0;
            g[d] = hold[d] ? lock[d] : 0;
            if (!hold[d])
                for (int k = rad[d] - 1; k >= 0; k--) begin
                    int l;
                    l = (ptr[d] + k) % rad[d];
                    if (lv[d][l]) begin
                        g[d] = l;
                        any[d] = 1'b1;
                    end
                end
            req[d] = hold[d] ? lv[d][g[d]] : any[d];
            core[d] = (d == 0) ? a_irdy : (bq.size() < 2);
            eo[d] = (rst && core[d] && (hold[d] || any[d])) ? 4'(1 << g[d]) : 4'd0;
            eop[d] = (d == 0) ? ld[0][g[0]][0] : 1'b1;
            xfer[d] = rst && req[d] && core[d];
        end
        chk("a_ready", 32'(a_ordy), 32'(eo[0]));
        chk("a_valid", 32'(a_ovalid), 32'(rst && req[0]));
        chk("a_data", 32'(a_odata), (rst && req[0]) ? 32'(ld[0][g[0]]) : 32'd0);
        chk("a_sel", 32'(a_sel), (rst && req[0]) ? 32'(g[0]) : 32'd0);
        chk("b_ready", 32'(b_ordy), 32'(eo[1][2:0]));
        chk("b_valid", 32'(b_ovalid), 32'(bq.size() > 0));
        chk("b_data", 32'(b_odata), (bq.size() > 0) ? 32'(bq[0][7:0]) : 32'd0);
        chk("b_sel", 32'(b_sel), (bq.size() > 0) ? 32'(bq[0][9:8]) : 32'd0);
        if (rr_exp >= 0) chk("rr_seq", 32'(a_sel), 32'(rr_exp));
        @(posedge clk);
        if (!rst) begin
            lock = '{-1, -1};
            ptr = '{0, 0};
            bq.delete();
        end else begin
            if (bq.size() > 0 && b_irdy) void'(bq.pop_front());
            for (int d = 0; d < 2; d++) begin
                if (xfer[d]) begin
                    if (d == 1) bq.push_back({2'(g[1]), ld[1][g[1]]});
                    lv[d][g[d]] = 1'b0;
                    if (eop[d]) begin
                        lock[d] = -1;
                        ptr[d] = (g[d] + 1) % rad[d];
                    end else begin
                        lock[d] = g[d];
                    end
                end else if (!hold[d] && any[d]) begin
                    lock[d] = g[d];
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        want_rst = 1'b1;
        a_data = '0; a_valid = '0; a_irdy = 1'b0;
        b_data = '0; b_valid = '0; b_irdy = 1'b0;
        lock = '{-1, -1};
        ptr = '{0, 0};
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 4; k++) begin
                lv[d][k] = 1'b0;
                ld[d][k] = '0;
            end
        pv = '{0, 0}; pe = 100; pr = 100; en = '{4'h0, 4'h0}; tog = 1'b0;
        step(-1);
        step(-1);
        want_rst = 1'b0;
        // all four lanes continuously valid with one-beat packets
        en = '{4'hf, 4'h7};
        pv = '{100, 50};
        for (int i = 0; i < 8; i++) step(i % 4);
        // random packets and backpressure
        pv = '{60, 60}; pe = 35; pr = 70;
        for (int i = 0; i < 250; i++) step(-1);
        // drain: finish any open packet, then let every lane empty
        pv = '{100, 100}; pe = 100; pr = 100;
        for (int i = 0; i < 4; i++) step(-1);
        pv = '{0, 0};
        for (int i = 0; i < 8; i++) step(-1);
        // lane1 waits under backpressure, then lane0 joins
        en[0] = 4'b0010; pv[0] = 100; pr = 0;
        for (int i = 0; i < 5; i++) step(-1);
        en[0] = 4'b0011; pr = 100;
        for (int i = 0; i < 6; i++) step(-1);
        // reset in the middle of a long lane0 packet
        en[0] = 4'b0001; pe = 0; pv = '{100, 100};
        for (int i = 0; i < 3; i++) step(-1);
        want_rst = 1'b1;
        step(-1);
        want_rst = 1'b0;
        en[0] = 4'b0011; pe = 100;
        for (int i = 0; i < 6; i++) step(-1);
        // skid buffer with downstream ready alternating, lane2 only
        en[1] = 4'b0100; tog = 1'b1;
        pv[0] = 50; pe = 40; pr = 60; en[0] = 4'hf;
        for (int i = 0; i < 14; i++) step(-1);
        // mixed random tail
        tog = 1'b0; en[1] = 4'h7; pv = '{50, 50};
        for (int i = 0; i < 300; i++) step(-1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
